// File: rtl/div_display_pkg.sv
// Shared state encoding and 7-segment glyphs for the divider result display.
// Segments are active-low, bit 0 = a ... bit 6 = g.
package div_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] seg_of_bcd(logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/div_result_display_bin2bcd_serial.sv
// Serial double-dabble: one binary bit per cycle, WIDTH cycles per conversion.
// done_o is high during the last shift cycle; bcd_o then holds the finished result.
module bin2bcd_serial #(
  parameter int WIDTH      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_o  = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[WIDTH-1]};
  assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign busy_o = busy_q;

  // NOTE: registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_o;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/div_result_display.sv
// Converts the divider's quotient/remainder to BCD and scans them onto an
// 8-digit multiplexed 7-segment display with a 'q'/'r' label on digit 7.
module div_result_display
  import div_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int WIDTH       = 16,
  parameter int BCD_DIGITS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] quotient_in,
  input  logic [WIDTH-1:0] remainder_in,
  input  logic             sel,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [7:0]       an
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_t      state_q, state_d;
  logic [WIDTH-1:0] rem_shadow_q;
  logic             conv_start, conv_done, conv_busy;
  logic [WIDTH-1:0] conv_bin;
  logic [BCD_W-1:0] conv_bcd;
  logic             store_q, commit;
  logic [BCD_W-1:0] q_hold_q, disp_q_q, disp_r_q;
  logic [CNT_W-1:0] refresh_q;
  logic [2:0]       scan_q;
  logic             sel_q;
  logic [BCD_W-1:0] shown, upper;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  bin2bcd_serial #(.WIDTH(WIDTH), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A fresh valid_in always wins: it aborts whatever conversion is running.
  always_comb begin
    state_d = state_q;
    if (valid_in) state_d = CONV_Q;
    else begin
      case (state_q)
        CONV_Q:  if (conv_done) state_d = CONV_R;
        CONV_R:  if (conv_done) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    conv_start = valid_in;
    conv_bin   = quotient_in;
    store_q    = 1'b0;
    commit     = 1'b0;
    if (!valid_in && conv_done) begin
      if (state_q == CONV_Q) begin
        store_q    = 1'b1;
        conv_start = 1'b1;
        conv_bin   = rem_shadow_q;
      end
      if (state_q == CONV_R) commit = 1'b1;
    end
  end

  // The converter's busy flop spans both passes and drops on the commit edge.
  assign busy = conv_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_shadow_q <= '0;
      q_hold_q     <= '0;
      disp_q_q     <= '0;
      disp_r_q     <= '0;
    end else begin
      if (valid_in) rem_shadow_q <= remainder_in;
      if (store_q)  q_hold_q     <= conv_bcd;
      if (commit) begin
        disp_q_q <= q_hold_q;
        disp_r_q <= conv_bcd;
      end
    end
  end

  // sel is taken at slot boundaries so a digit never changes mid-slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      scan_q    <= '0;
      sel_q     <= 1'b0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV-1)) begin
      refresh_q <= '0;
      scan_q    <= scan_q + 3'd1;
      sel_q     <= sel;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  always_comb begin
    shown = sel_q ? disp_r_q : disp_q_q;
    upper = shown >> (4 * scan_q);
    an_d  = ~(8'd1 << scan_q);
    seg_d = SEG_BLANK;
    if (scan_q == 3'd7) seg_d = sel_q ? SEG_R : SEG_Q;
    else if (int'(scan_q) < BCD_DIGITS && (scan_q == 3'd0 || upper != '0))
      seg_d = seg_of_bcd(upper[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_div_result_display.sv
// Random and directed results pushed to a scoreboard; a monitor checks busy
// windows, scan order and every undisturbed display frame against a decimal model.
module tb_div_result_display;

  localparam int REFRESH_DIV = 4;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int          blen;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] quotient_in = '0;
  logic [15:0] remainder_in = '0;
  logic        sel = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic [7:0]  an;

  div_result_display #(.REFRESH_DIV(REFRESH_DIV), .WIDTH(16), .BCD_DIGITS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .quotient_in  (quotient_in),
    .remainder_in (remainder_in),
    .sel          (sel),
    .busy         (busy),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  txn_t        pend[$];
  int unsigned m_q = 0, m_r = 0;
  int          last_valid = -1000;
  int          run_start  = 0;

  function automatic logic [6:0] glyph(int unsigned d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int unsigned v, bit s, int idx);
    int unsigned p = 1;
    if (idx == 7) return s ? 7'b0101111 : 7'b0011000;
    if (idx >= 5) return 7'h7F;
    for (int k = 0; k < idx; k++) p *= 10;
    if (idx > 0 && v < p) return 7'h7F;
    return glyph((v / p) % 10);
  endfunction

  // ---------------- stimulus ----------------
  task automatic hold(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int unsigned q, int unsigned r);
    txn_t t;
    int   blen;
    if (pend.size() > 0 && cyc - last_valid <= 32) begin
      t    = pend.pop_back();
      blen = cyc - run_start + 32;
    end else begin
      run_start = cyc;
      blen      = 32;
    end
    last_valid = cyc;
    pend.push_back('{q, r, blen});
    quotient_in  = 16'(q);
    remainder_in = 16'(r);
    valid_in     = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst      = 1'b1;
    valid_in = 1'b0;
    pend.delete();
    hold(n);
    rst = 1'b0;
  endtask

  task automatic view_both();
    sel = 1'b0;
    hold(120);
    sel = 1'b1;
    hold(120);
    sel = 1'b0;
  endtask

  initial begin
    hold(3);
    rst = 1'b0;
    hold(80);
    send(12345, 6);      hold(40); view_both();
    send(65535, 0);      hold(40); view_both();
    send(100, 7);        hold(40); view_both();
    send(7, 1);          hold(9);  send(42, 3); hold(40); view_both();
    send(999, 5);        hold(19); do_reset(3); view_both();
    for (int it = 0; it < 12; it++) begin
      send($urandom_range(0, 65535), $urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) begin
        hold($urandom_range(0, 34));
        send($urandom_range(0, 65535), $urandom_range(0, 65535));
      end
      hold(40);
      sel = 1'($urandom_range(0, 1));
      hold(120);
      sel = ~sel;
      hold(120);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- monitor ----------------
  logic [6:0] frame [8];
  bit         busy_prev, frame_started, frame_dirty, dirty_next, sel_prev;
  int         busy_run, last_digit, slot_len, digit;
  logic [7:0] last_an;
  txn_t       got;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        check("reset_seg", seg, 7'h7F);
        check("reset_an", an, 8'hFF);
        check("reset_busy", busy, 0);
        m_q = 0; m_r = 0;
        busy_prev = 0; busy_run = 0;
        last_digit = -1; last_an = 8'hFF; slot_len = 0;
        frame_started = 0; frame_dirty = 0; dirty_next = 0;
        sel_prev = sel;
        continue;
      end

      if (sel !== sel_prev) begin
        frame_dirty = 1; dirty_next = 1; sel_prev = sel;
      end

      if (busy) busy_run++;
      else if (busy_prev) begin
        check("commit_pending", (pend.size() > 0), 1);
        if (pend.size() > 0) begin
          got = pend.pop_front();
          check("busy_len", busy_run, got.blen);
          m_q = got.q;
          m_r = got.r;
        end
        busy_run = 0;
        frame_dirty = 1; dirty_next = 1;
      end
      busy_prev = busy;

      digit = -1;
      for (int i = 0; i < 8; i++) if (!an[i]) digit = i;
      check("an_onehot", $countones(~an), 1);

      if (an !== last_an) begin
        if (last_digit >= 0) begin
          check("scan_order", digit, (last_digit + 1) % 8);
          check("slot_len", slot_len, REFRESH_DIV);
        end
        if (digit == 0) begin
          if (frame_started && !frame_dirty)
            for (int k = 0; k < 8; k++)
              check($sformatf("digit%0d_val%0d_sel%0d", k, sel_prev ? m_r : m_q, sel_prev),
                    frame[k], exp_seg(sel_prev ? m_r : m_q, sel_prev, k));
          frame_started = 1;
          frame_dirty   = dirty_next;
          dirty_next    = 0;
        end
        last_digit = digit;
        last_an    = an;
        slot_len   = 0;
      end
      slot_len++;
      if (digit >= 0) frame[digit] = seg;
    end
  end

endmodule
